data_ram_bank_xbar: RTL
=======================

// Module: data_ram_bank_xbar
// PURPOSE
//  Parametrised crossbar between NUM_REQ scratchpad requesters (LSU ports) and NUM_BANKS data-RAM banks.
//  Decodes each address against the data-RAM window, arbitrates round-robin per bank and drives bank SRAMs.
//  Returns read data / error with fixed 1-cycle latency. Replaces the fixed 4-bank static data-RAM decode.
// PARAMETERS
//  NUM_REQ    4             number of requester ports
//  NUM_BANKS  4             number of data-RAM banks; power of 2, >=1
//  BANK_SIZE  32'h8000      bytes per bank; power of 2
//  BASE_ADDR  32'h00008000  first byte of data-RAM window; BANK_SIZE-aligned
//  DATA_W     32            data width; byte enables = DATA_W/8
// PORTS
//  clk                     in   1                   clock
//  reset                   in   1                   synchronous, active-high reset
//  req_valid_i             in   NUM_REQ             request valid per requester
//  req_ready_o             out  NUM_REQ             request accepted this cycle (grant)
//  req_we_i                in   NUM_REQ             1 = write, 0 = read
//  req_addr_i              in   NUM_REQ x 32        byte address; bits [1:0] ignored
//  req_wdata_i             in   NUM_REQ x DATA_W    write data
//  req_be_i                in   NUM_REQ x DATA_W/8  byte enables
//  rsp_valid_o             out  NUM_REQ             response valid; no backpressure
//  rsp_rdata_o             out  NUM_REQ x DATA_W    read data (0 for writes and errors)
//  rsp_err_o               out  NUM_REQ             address outside window
//  bank_req_o              out  NUM_BANKS           bank access strobe
//  bank_we_o               out  NUM_BANKS           bank write enable
//  bank_addr_o             out  NUM_BANKS x log2(BANK_SIZE/4)  word index inside bank
//  bank_wdata_o            out  NUM_BANKS x DATA_W  bank write data
//  bank_be_o               out  NUM_BANKS x DATA_W/8 bank byte enables
//  bank_rdata_i            in   NUM_BANKS x DATA_W  bank read data, valid 1 cycle after bank_req_o
// BEHAVIOUR
//  - Decode (comb): off = addr - BASE_ADDR; in range iff addr >= BASE_ADDR and off < NUM_BANKS*BANK_SIZE;
//    bank = off / BANK_SIZE; word = off[log2(BANK_SIZE)-1:2].
//  - Per bank: round-robin among requesters targeting it; priority starts at rr_ptr[bank].
//    Granted r: req_ready_o[r]=1 same cycle; bank_* driven combinationally from r.
//    Grant updates rr_ptr[bank] <= (r+1) mod NUM_REQ; no grant -> pointer unchanged.
//  - Out-of-range request: req_ready_o=1 immediately, no bank access, next cycle rsp_valid=1, rsp_err=1, rdata=0.
//  - Accepted request -> exactly one response next cycle on same requester port; registers hold
//    {valid, err, we, bank idx} per requester; rdata muxed from bank_rdata_i[bank idx], 0 if we or err.
//  - Requester not granted keeps req_valid_i/payload stable; requester may issue back-to-back every cycle.
//  - Writes also respond (rsp_valid=1, rdata=0) for completion tracking.
//  - Unselected banks: bank_req_o=0, other bank_* outputs 0.
//  - Reset: rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, all rr_ptr=0; req_ready_o=0 while reset high.
//    Requests accepted the cycle reset asserts are dropped; no response after reset.
//  - Address overflow: addr < BASE_ADDR must not wrap into a bank (compare before subtract).
// STRUCTURE
//  - mem_map_pkg: mem_map_t {idx,start_addr,end_addr}, RAM_BANK_SIZE, DATA_RAM_START_ADDRESS;
//    add function bank_rule(i) returning rule for bank i so rules scale with NUM_BANKS.
//  - Sub-module rr_arbiter #(N): req[N], ptr in, gnt onehot + gnt_idx out; one instance per bank.
//  - Parameter checks (power-of-2, alignment) as elaboration-time $error.
// TESTING
//  - Single read: req0 addr 0x00008010 -> bank0 word 4, rsp next cycle with bank0 rdata, err=0.
//  - Bank select: req1 write 0x00010004 -> bank1 word 1, we=1, be passed; rsp_valid, rdata=0.
//  - Conflict: req0..3 all read bank2 4 cycles -> grants 0,1,2,3 in order; each rsp 1 cycle after grant.
//  - Parallel: req0->bank0, req1->bank3 same cycle -> both ready, both rsp next cycle, no stall.
//  - Error: addr 0x00004000 and 0x00028000 -> ready=1, no bank_req, rsp_err=1, rdata=0.
//  - Reset mid-traffic: reset high with grants pending -> next cycle rsp_valid=0, rr_ptr=0 (req0 wins first).

Source files
------------

// File: rtl/mem_map_pkg.sv
// Data-RAM memory map: bank window constants and the per-bank address rule.
// Bank i covers [base + i*size, base + (i+1)*size - 1].
package mem_map_pkg;

  localparam logic [31:0] RAM_BANK_SIZE          = 32'h0000_8000;
  localparam logic [31:0] DATA_RAM_START_ADDRESS = 32'h0000_8000;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } mem_map_t;

  function automatic mem_map_t bank_rule(input int unsigned i, input logic [31:0] base,
                                         input logic [31:0] size);
    mem_map_t rule;
    rule.idx        = 32'(i);
    rule.start_addr = base + 32'(i) * size;
    rule.end_addr   = rule.start_addr + size - 32'd1;
    return rule;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search for a requester starts at i_ptr and wraps.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic          w_found;
  logic [IW-1:0] w_k;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_k       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_k = IW'((32'(i_ptr) + i) % N);
      if (!w_found && i_req[w_k]) begin
        o_gnt[w_k] = 1'b1;
        o_gnt_idx  = w_k;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_ram_bank_xbar.sv
// Crossbar from NUM_REQ LSU ports onto NUM_BANKS data-RAM banks, round-robin per bank,
// with a fixed one-cycle response path (read data, write completion or window error).
module data_ram_bank_xbar
  import mem_map_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_BANKS = 4,
  parameter logic [31:0] BANK_SIZE = RAM_BANK_SIZE,
  parameter logic [31:0] BASE_ADDR = DATA_RAM_START_ADDRESS,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned AW   = $clog2(BANK_SIZE / 4),
  localparam int unsigned BE_W = DATA_W / 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0]                 req_we_i,
  input  logic [NUM_REQ-1:0][31:0]           req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_wdata_i,
  input  logic [NUM_REQ-1:0][BE_W-1:0]       req_be_i,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  output logic [NUM_REQ-1:0][DATA_W-1:0]     rsp_rdata_o,
  output logic [NUM_REQ-1:0]                 rsp_err_o,
  output logic [NUM_BANKS-1:0]               bank_req_o,
  output logic [NUM_BANKS-1:0]               bank_we_o,
  output logic [NUM_BANKS-1:0][AW-1:0]       bank_addr_o,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]   bank_wdata_o,
  output logic [NUM_BANKS-1:0][BE_W-1:0]     bank_be_o,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]   bank_rdata_i
);

  localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_BANKS == 0 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_chk_nb
    $error("NUM_BANKS must be a power of two");
  end
  if (BANK_SIZE < 32'd8 || (BANK_SIZE & (BANK_SIZE - 32'd1)) != 32'd0) begin : g_chk_bs
    $error("BANK_SIZE must be a power of two of at least 8 bytes");
  end
  if ((BASE_ADDR & (BANK_SIZE - 32'd1)) != 32'd0) begin : g_chk_base
    $error("BASE_ADDR must be BANK_SIZE-aligned");
  end

  logic [NUM_REQ-1:0][NUM_BANKS-1:0] w_hit;
  logic [NUM_REQ-1:0]                w_inr;
  logic [NUM_REQ-1:0][BW-1:0]        w_bsel;
  logic [NUM_BANKS-1:0][NUM_REQ-1:0] w_breq;
  logic [NUM_BANKS-1:0][NUM_REQ-1:0] w_gnt;
  logic [NUM_BANKS-1:0][RW-1:0]      w_gidx;
  logic [NUM_BANKS-1:0][RW-1:0]      r_ptr;
  logic [NUM_REQ-1:0]                r_vld, r_err, r_we;
  logic [NUM_REQ-1:0][BW-1:0]        r_bank;

  // Bounds are compared on the raw address, so nothing below the window can wrap into a bank.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_dec
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_rule
      localparam mem_map_t RULE = bank_rule(b, BASE_ADDR, BANK_SIZE);
      assign w_hit[r][b] = (req_addr_i[r] >= RULE.start_addr) && (req_addr_i[r] <= RULE.end_addr);
    end
  end

  always_comb begin
    w_inr  = '0;
    w_bsel = '0;
    w_breq = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      w_inr[r] = |w_hit[r];
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (w_hit[r][b]) w_bsel[r] = BW'(b);
        w_breq[b][r] = !reset && req_valid_i[r] && w_hit[r][b];
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
    rr_arbiter #(.N(NUM_REQ)) u_arb (
      .i_req     (w_breq[b]),
      .i_ptr     (r_ptr[b]),
      .o_gnt     (w_gnt[b]),
      .o_gnt_idx (w_gidx[b])
    );
  end

  always_comb begin
    bank_req_o   = '0;
    bank_we_o    = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    req_ready_o  = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (|w_gnt[b]) begin
        bank_req_o[b]   = 1'b1;
        bank_we_o[b]    = req_we_i[w_gidx[b]];
        bank_addr_o[b]  = req_addr_i[w_gidx[b]][AW+1:2];
        bank_wdata_o[b] = req_wdata_i[w_gidx[b]];
        bank_be_o[b]    = req_be_i[w_gidx[b]];
      end
    end
    // Out-of-window requests are accepted at once and answered with an error.
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_ready_o[r] = !reset && req_valid_i[r] && !w_inr[r];
      for (int unsigned b = 0; b < NUM_BANKS; b++)
        if (w_gnt[b][r]) req_ready_o[r] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= '0;
      r_vld  <= '0;
      r_err  <= '0;
      r_we   <= '0;
      r_bank <= '0;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++)
        if (|w_gnt[b]) r_ptr[b] <= (w_gidx[b] == RW'(NUM_REQ - 1)) ? '0 : w_gidx[b] + 1'b1;
      r_vld  <= req_ready_o;
      r_err  <= ~w_inr;
      r_we   <= req_we_i;
      r_bank <= w_bsel;
    end
  end

  always_comb begin
    rsp_rdata_o = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++)
      if (r_vld[r] && !r_we[r] && !r_err[r]) rsp_rdata_o[r] = bank_rdata_i[r_bank[r]];
  end

  assign rsp_valid_o = r_vld;
  assign rsp_err_o   = r_vld & r_err;

endmodule
